// File: rtl/spi_cmd_pkg.sv
// Shared constants for the SPI command decoder: opcodes, FSM encoding and
// command-word field positions.
package spi_cmd_pkg;

  // Opcodes carried in the top byte of the command word
  localparam logic [7:0] OP_NOP    = 8'h00;
  localparam logic [7:0] OP_WRITE  = 8'h01;
  localparam logic [7:0] OP_SET    = 8'h02;
  localparam logic [7:0] OP_CLEAR  = 8'h03;
  localparam logic [7:0] OP_TOGGLE = 8'h04;

  // FSM state encoding
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_CAPTURE = 2'd1;
  localparam logic [1:0] ST_EXEC    = 2'd2;

  // Command word field positions
  localparam int unsigned OPC_MSB  = 31;
  localparam int unsigned OPC_LSB  = 24;
  localparam int unsigned ADDR_MSB = 23;
  localparam int unsigned ADDR_LSB = 16;
  localparam int unsigned DATA_MSB = 15;
  localparam int unsigned DATA_LSB = 0;

  // New register value for a register-modifying opcode; anything else keeps cur
  function automatic logic [15:0] apply_op(input logic [7:0]  opc,
                                           input logic [15:0] cur,
                                           input logic [15:0] data);
    logic [15:0] res;
    res = cur;
    unique case (opc)
      OP_WRITE:  res = data;
      OP_SET:    res = cur | data;
      OP_CLEAR:  res = cur & ~data;
      OP_TOGGLE: res = cur ^ data;
      default:   res = cur;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchronizer for an asynchronous pin, reset to the idle-high level,
// with a rising-edge pulse derived from one extra history flop.
module sync_edge #(
  parameter int unsigned Stages = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic async_i,
  output logic sync_o,
  output logic rise_o
);

  logic [Stages-1:0] sync_q;
  logic              prev_q;

  // Shift the pin through the synchronizer chain and keep the previous level
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[Stages-2:0], async_i};
      prev_q <= sync_q[Stages-1];
    end
  end

  // Level and edge outputs
  always_comb begin
    sync_o = sync_q[Stages-1];
    rise_o = sync_q[Stages-1] & ~prev_q;
  end

endmodule

// File: rtl/spi_cmd_decoder.sv
// Applies the 32-bit SPI receive word to a bank of control registers once per
// chip-select frame, reporting each command with a done or error pulse.
module spi_cmd_decoder
  import spi_cmd_pkg::*;
#(
  parameter int unsigned NUM_REGS    = 8,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       SS,
  input  logic [31:0]                byteRx,
  output logic [NUM_REGS*DATA_W-1:0] REGS,
  output logic                       CMD_DONE,
  output logic                       CMD_ERR,
  output logic [7:0]                 ERR_COUNT,
  output logic [31:0]                LAST_CMD
);

  logic              ss_sync;
  logic              ss_rise;

  logic [1:0]        state_q, state_d;
  logic [31:0]       cmd_q, cmd_d;
  logic [31:0]       last_q, last_d;
  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [7:0]        cnt_q, cnt_d;

  logic [7:0]        opc;
  logic [7:0]        addr;
  logic [15:0]       data;
  logic              addr_in_range;
  logic              cmd_ok;

  sync_edge #(
    .Stages (SYNC_STAGES)
  ) u_ss_sync (
    .clk_i   (CLK),
    .rst_i   (RST),
    .async_i (SS),
    .sync_o  (ss_sync),
    .rise_o  (ss_rise)
  );

  // Split the held command word into its fields and classify it
  always_comb begin
    opc           = cmd_q[OPC_MSB:OPC_LSB];
    addr          = cmd_q[ADDR_MSB:ADDR_LSB];
    data          = cmd_q[DATA_MSB:DATA_LSB];
    addr_in_range = ({24'd0, addr} < NUM_REGS);
    cmd_ok        = 1'b0;
    unique case (opc)
      OP_NOP:                                cmd_ok = 1'b1;
      OP_WRITE, OP_SET, OP_CLEAR, OP_TOGGLE: cmd_ok = addr_in_range;
      default:                               cmd_ok = 1'b0;
    endcase
  end

  // Next-state: wait for end of frame, capture the word, then execute it
  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    last_d  = last_q;
    regs_d  = regs_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (ss_rise) state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        // A chip-select that already dropped again was a glitch: drop it silently
        if (ss_sync) begin
          cmd_d   = byteRx;
          last_d  = byteRx;
          state_d = ST_EXEC;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EXEC: begin
        state_d = ST_IDLE;
        if (cmd_ok) begin
          done_d = 1'b1;
          for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (addr == 8'(i)) regs_d[i] = apply_op(opc, regs_q[i], data);
          end
        end else begin
          err_d = 1'b1;
          if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, register bank and status registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      cmd_q   <= '0;
      last_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      last_q  <= last_d;
      done_q  <= done_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      regs_q  <= regs_d;
    end
  end

  // Flatten the register bank and drive the status outputs
  always_comb begin
    REGS = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) REGS[i*DATA_W +: DATA_W] = regs_q[i];
    CMD_DONE  = done_q;
    CMD_ERR   = err_q;
    ERR_COUNT = cnt_q;
    LAST_CMD  = last_q;
  end

endmodule
